// File: rtl/ln_pkg.sv
// Shared types, default parameters and fixed-point helpers for the normalize pipeline.
// Helpers work on 64-bit signed values so every lane width fits without overflow.
package ln_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int LANES_DEF   = 16;
   localparam int VEC_LEN_DEF = 64;
   localparam int DATA_W_DEF  = 16;
   localparam int FRAC_DEF    = 10;
   localparam int INV_W_DEF   = 17;

   // Round half up, then drop the fractional bits.
   function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v, input int frac);
      return (v + (64'sd1 <<< (frac - 1))) >>> frac;
   endfunction

   function automatic logic sat_hit(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return (v > hi) || (v < lo);
   endfunction

   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/ln_normalize_pipe_lane.sv
// One lane of the normalize datapath: center and scale, apply gamma, add beta.
// All three stages advance together on i_en; gamma and beta ride along with their beat.
module ln_norm_lane
   import ln_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC   = FRAC_DEF,
   parameter int INV_W  = INV_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_mode,
   input  logic [DATA_W-1:0] i_mean,
   input  logic [INV_W-1:0]  i_inv,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_gamma,
   input  logic [DATA_W-1:0] i_beta,
   output logic [DATA_W-1:0] o_y,
   output logic              o_sat2,
   output logic              o_sat3
);

   localparam int D_W = DATA_W + 1;
   localparam int P_W = D_W + INV_W;
   localparam int Q_W = 2 * DATA_W;

   logic signed [D_W-1:0]    w_x_ext;
   logic signed [D_W-1:0]    w_m_ext;
   logic signed [D_W-1:0]    w_d;
   logic signed [P_W-1:0]    w_p;
   logic signed [63:0]       w_r2;
   logic signed [63:0]       w_n64;
   logic signed [DATA_W-1:0] w_n;
   logic signed [Q_W-1:0]    w_q;
   logic signed [63:0]       w_s3;
   logic signed [63:0]       w_y64;

   logic signed [P_W-1:0]    r_p;
   logic signed [DATA_W-1:0] r_gamma1;
   logic signed [DATA_W-1:0] r_beta1;
   logic signed [Q_W-1:0]    r_q;
   logic signed [DATA_W-1:0] r_beta2;
   logic        [DATA_W-1:0] r_y;

   assign w_x_ext = $signed({i_x[DATA_W-1], i_x});
   assign w_m_ext = $signed({i_mean[DATA_W-1], i_mean});
   assign w_d     = i_mode ? w_x_ext : (w_x_ext - w_m_ext);
   assign w_p     = P_W'(w_d) * P_W'($signed(i_inv));

   assign w_r2    = rnd_shift(64'(r_p), FRAC);
   assign w_n64   = sat_clip(w_r2, DATA_W);
   assign w_n     = DATA_W'(w_n64);
   assign o_sat2  = sat_hit(w_r2, DATA_W);
   assign w_q     = Q_W'(w_n) * Q_W'(r_gamma1);

   // Beta is added after rounding, so the sum can overflow independently of q.
   assign w_s3    = rnd_shift(64'(r_q), FRAC) + 64'(r_beta2);
   assign w_y64   = sat_clip(w_s3, DATA_W);
   assign o_sat3  = sat_hit(w_s3, DATA_W);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_p      <= '0;
         r_gamma1 <= '0;
         r_beta1  <= '0;
         r_q      <= '0;
         r_beta2  <= '0;
         r_y      <= '0;
      end else if (i_en) begin
         r_p      <= w_p;
         r_gamma1 <= i_gamma;
         r_beta1  <= i_beta;
         r_q      <= w_q;
         r_beta2  <= r_beta1;
         r_y      <= DATA_W'(w_y64);
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/ln_normalize_pipe.sv
// Streaming LayerNorm/RMSNorm output stage: control FSM, valid/last pipe and LANES datapath lanes.
// Statistics are latched at start; one global enable stalls the whole pipe on output backpressure.
module ln_normalize_pipe
   import ln_pkg::*;
#(
   parameter int LANES   = LANES_DEF,
   parameter int VEC_LEN = VEC_LEN_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int FRAC    = FRAC_DEF,
   parameter int INV_W   = INV_W_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_mode,
   input  logic [31:0]             i_mean,
   input  logic [INV_W-1:0]        i_inv_sqrt,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [LANES*DATA_W-1:0] i_data,
   input  logic [LANES*DATA_W-1:0] i_gamma,
   input  logic [LANES*DATA_W-1:0] i_beta,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [LANES*DATA_W-1:0] o_data,
   output logic                    o_last,
   output logic                    o_busy,
   output logic                    o_sat
);

   localparam int NBEATS = VEC_LEN / LANES;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_mode;
   logic [DATA_W-1:0]  r_mean;
   logic [INV_W-1:0]   r_inv;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_v1, r_v2, r_v3;
   logic               r_t1, r_t2, r_t3;
   logic               r_sat;

   logic               w_en;
   logic               w_in_hs;
   logic               w_last_in;
   logic               w_start;
   logic [LANES-1:0]   w_sat2;
   logic [LANES-1:0]   w_sat3;

   assign w_en      = !r_v3 || i_ready;
   assign o_ready   = (r_state == RUN) && w_en;
   assign w_in_hs   = i_valid && o_ready;
   assign w_last_in = (r_cnt == CNT_W'(NBEATS - 1));
   assign w_start   = (r_state == IDLE) && i_start;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_next = RUN;
         RUN:     if (w_in_hs && w_last_in) w_state_next = DRAIN;
         DRAIN:   if (r_v3 && r_t3 && i_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_mode  <= 1'b0;
         r_mean  <= '0;
         r_inv   <= '0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_t1    <= 1'b0;
         r_t2    <= 1'b0;
         r_t3    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_mode <= i_mode;
            r_mean <= i_mean[DATA_W-1:0];
            r_inv  <= i_inv_sqrt;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
         end else begin
            if (w_in_hs)
               r_cnt <= w_last_in ? '0 : r_cnt + CNT_W'(1);
            // Clamp flags only count when a real beat is moving into the next stage.
            if (w_en && ((r_v1 && |w_sat2) || (r_v2 && |w_sat3)))
               r_sat <= 1'b1;
         end
         if (w_en) begin
            r_v1 <= w_in_hs;
            r_t1 <= w_in_hs && w_last_in;
            r_v2 <= r_v1;
            r_t2 <= r_t1;
            r_v3 <= r_v2;
            r_t3 <= r_t2;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         ln_norm_lane #(
            .DATA_W (DATA_W),
            .FRAC   (FRAC),
            .INV_W  (INV_W)
         ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (w_en),
            .i_mode  (r_mode),
            .i_mean  (r_mean),
            .i_inv   (r_inv),
            .i_x     (i_data[DATA_W*gi +: DATA_W]),
            .i_gamma (i_gamma[DATA_W*gi +: DATA_W]),
            .i_beta  (i_beta[DATA_W*gi +: DATA_W]),
            .o_y     (o_data[DATA_W*gi +: DATA_W]),
            .o_sat2  (w_sat2[gi]),
            .o_sat3  (w_sat3[gi])
         );
      end

      if (DATA_W < 32) begin : g_mean_hi
         logic w_unused_mean_hi;
         assign w_unused_mean_hi = ^i_mean[31:DATA_W];
      end
   endgenerate

   assign o_valid = r_v3;
   assign o_last  = r_t3;
   assign o_busy  = (r_state != IDLE);
   assign o_sat   = r_sat;

endmodule

// File: tb/tb_ln_normalize_pipe.sv
// Directed bench for ln_normalize_pipe with 4 lanes, 2 beats per vector, Q.10 scaling.
// Expected outputs are hand-computed constants queued per accepted beat and matched in order.
module tb_ln_normalize_pipe;

   localparam int LANES   = 4;
   localparam int VEC_LEN = 8;
   localparam int NBEATS  = VEC_LEN / LANES;
   localparam int DATA_W  = 16;
   localparam int FRAC    = 10;
   localparam int INV_W   = 17;
   localparam int PW      = LANES * DATA_W;

   logic              clk = 1'b0;
   logic              i_rst, i_start, i_mode, i_valid, i_ready;
   logic [31:0]       i_mean;
   logic [INV_W-1:0]  i_inv_sqrt;
   logic [PW-1:0]     i_data, i_gamma, i_beta;
   logic              o_ready, o_valid, o_last, o_busy, o_sat;
   logic [PW-1:0]     o_data;

   int                n_chk = 0;
   int                n_fail = 0;
   int                cyc = 0;
   logic [PW-1:0]     exp_q[$];
   bit                last_q[$];
   int                acc_q[$];
   logic [PW-1:0]     cur_exp;
   int                in_beats, out_beats;
   bit                chk_lat;
   bit                stalled_prev;
   logic [PW-1:0]     prev_data;

   always #5 clk = ~clk;

   ln_normalize_pipe #(
      .LANES(LANES), .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .FRAC(FRAC), .INV_W(INV_W)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_mean(i_mean), .i_inv_sqrt(i_inv_sqrt), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_gamma(i_gamma), .i_beta(i_beta), .o_valid(o_valid),
      .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_sat(o_sat)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample settled outputs, score handshakes, then advance one clock.
   task automatic step();
      #1;
      if (o_valid && !i_ready)
         check_eq("stall_oready", o_ready, 0);
      if (stalled_prev)
         check_eq("stall_hold", {o_valid, o_data[62:0]}, {1'b1, prev_data[62:0]});
      stalled_prev = o_valid && !i_ready;
      prev_data    = o_data;
      if (o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", o_valid, 0);
         end else begin
            check_eq("out_data", o_data, exp_q.pop_front());
            check_eq("out_last", o_last, last_q.pop_front());
            if (chk_lat)
               check_eq("latency", 64'(cyc - acc_q.pop_front()), 3);
            else
               void'(acc_q.pop_front());
            out_beats++;
         end
      end
      if (i_valid && o_ready) begin
         exp_q.push_back(cur_exp);
         last_q.push_back(in_beats == NBEATS - 1);
         acc_q.push_back(cyc);
         in_beats++;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic run_vec(input string tag, input logic mode, input logic [31:0] mean,
                          input logic [INV_W-1:0] inv, input logic [PW-1:0] x,
                          input logic [PW-1:0] g, input logic [PW-1:0] b,
                          input logic [PW-1:0] ey, input bit bp, input bit lat,
                          input bit mid_start, input bit exp_sat);
      bit done;
      i_start = 1'b1; i_mode = mode; i_mean = mean; i_inv_sqrt = inv;
      i_valid = 1'b0; i_ready = 1'b1;
      step();
      i_start = 1'b0;
      check_eq({tag, "_busy"}, o_busy, 1);
      check_eq({tag, "_sat_clr"}, o_sat, 0);
      cur_exp = ey; chk_lat = lat; in_beats = 0; out_beats = 0;
      i_data = x; i_gamma = g; i_beta = b;
      done = 1'b0;
      for (int k = 0; k < 60; k++) begin
         i_ready = bp ? (k % 2 == 0) : 1'b1;
         i_valid = (in_beats < NBEATS);
         if (mid_start && in_beats >= 1) begin
            i_start = 1'b1; i_mode = ~mode; i_mean = 32'd0; i_inv_sqrt = 17'd2048;
         end
         if (in_beats == NBEATS && exp_q.size() == 0 && !o_busy) begin
            done = 1'b1;
            break;
         end
         step();
      end
      i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_beats"}, out_beats, NBEATS);
      check_eq({tag, "_sat"}, o_sat, exp_sat);
      $display("vector %s: %0d beats out, sat=%0b", tag, out_beats, o_sat);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_mean = '0; i_inv_sqrt = '0; i_data = '0; i_gamma = '0; i_beta = '0;
      cur_exp = '0; in_beats = 0; out_beats = 0; chk_lat = 1'b0; stalled_prev = 1'b0;
      prev_data = '0;
      step();
      step();
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_sat", o_sat, 0);
      check_eq("rst_ready", o_ready, 0);
      check_eq("rst_data", o_data, 0);
      check_eq("rst_last", o_last, 0);
      i_rst = 1'b0;
      step();

      // i_valid in IDLE must not be accepted
      i_valid = 1'b1; i_data = {4{16'd1124}};
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("idle_ready", o_ready, 0);
         check_eq("idle_busy", o_busy, 0);
      end
      i_valid = 1'b0;
      check_eq("idle_accepts", in_beats, 0);

      run_vec("basic", 1'b0, 32'd100, 17'd1024, {4{16'd1124}}, {4{16'd1024}}, {4{16'd5}},
              {4{16'd1029}}, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("rms", 1'b1, 32'd100, 17'd1024, {4{16'd1124}}, {4{16'd1024}}, {4{16'd5}},
              {4{16'd1129}}, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("lanes", 1'b0, 32'd100, 17'd512, {16'd99, 16'd100, 16'd103, 16'd1124},
              {4{16'd1536}}, {4{16'd5}}, {16'd5, 16'd5, 16'd8, 16'd773},
              1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("neg", 1'b0, 32'd100, 17'd1024, {16'd0, 16'hFED4, 16'd200, 16'd1124},
              {4{16'd1024}}, {4{16'd5}}, {16'hFFA1, 16'hFE75, 16'd105, 16'd1029},
              1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("sat", 1'b0, 32'hFFFF8000, 17'd1024, {4{16'h7FFF}}, {4{16'd1024}},
              {4{16'd100}}, {4{16'h7FFF}}, 1'b0, 1'b1, 1'b0, 1'b1);
      run_vec("after_sat", 1'b0, 32'd100, 17'd1024, {4{16'd1124}}, {4{16'd1024}},
              {4{16'd5}}, {4{16'd1029}}, 1'b0, 1'b1, 1'b0, 1'b0);
      run_vec("backpressure", 1'b0, 32'd100, 17'd1024, {16'd0, 16'hFED4, 16'd200, 16'd1124},
              {4{16'd1024}}, {4{16'd5}}, {16'hFFA1, 16'hFE75, 16'd105, 16'd1029},
              1'b1, 1'b0, 1'b0, 1'b0);
      run_vec("start_in_run", 1'b0, 32'd100, 17'd1024, {4{16'd1124}}, {4{16'd1024}},
              {4{16'd5}}, {4{16'd1029}}, 1'b0, 1'b1, 1'b1, 1'b0);

      // Reset after one accepted beat discards it
      i_start = 1'b1; i_mode = 1'b0; i_mean = 32'd100; i_inv_sqrt = 17'd1024;
      i_gamma = {4{16'd1024}}; i_beta = {4{16'd5}}; i_data = {4{16'd1124}};
      cur_exp = {4{16'd1029}}; in_beats = 0;
      step();
      i_start = 1'b0; i_valid = 1'b1;
      step();
      check_eq("midrst_accepted", in_beats, 1);
      i_valid = 1'b0; i_rst = 1'b1;
      step();
      check_eq("midrst_valid", o_valid, 0);
      check_eq("midrst_busy", o_busy, 0);
      check_eq("midrst_ready", o_ready, 0);
      i_rst = 1'b0;
      exp_q.delete(); last_q.delete(); acc_q.delete(); stalled_prev = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("midrst_quiet", o_valid, 0);
      end
      run_vec("post_reset", 1'b0, 32'd100, 17'd1024, {4{16'd1124}}, {4{16'd1024}},
              {4{16'd5}}, {4{16'd1029}}, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ln_normalize_pipe.md
LN_NORMALIZE_PIPE -- requirements
Module: ln_normalize_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16: elements per beat.
REQ-002 SHALL have parameter VEC_LEN, default 64: vector length, an integer multiple of LANES (NBEATS = VEC_LEN/LANES).
REQ-003 SHALL have parameter DATA_W, default 16: signed width of x, gamma, beta and y.
REQ-004 SHALL have parameter FRAC, default 10: fractional bits of inv_sqrt and gamma.
REQ-005 SHALL have parameter INV_W, default 17: signed width of inv_sqrt.
REQ-006 SHALL have ports, in this order:
- i_clk  in  1  the single clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  latches statistics and mode; starts one vector.
- i_mode  in  1  0 = LayerNorm (subtract mean); 1 = RMSNorm (mean ignored).
- i_mean  in  32  signed mean; bits [DATA_W-1:0] are used.
- i_inv_sqrt  in  INV_W  signed Q.FRAC reciprocal std-dev.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid & o_ready.
- i_data  in  LANES*DATA_W  packed x; lane k at [DATA_W*k +: DATA_W].
- i_gamma  in  LANES*DATA_W  packed Q.FRAC gamma, aligned with i_data.
- i_beta  in  LANES*DATA_W  packed beta, aligned with i_data.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts when o_valid & i_ready.
- o_data  out  LANES*DATA_W  packed y.
- o_last  out  1  high on the final output beat of a vector.
- o_busy  out  1  high in every state except IDLE.
- o_sat  out  1  sticky: a lane saturated during the current vector.

Function
REQ-007 SHALL implement FSM IDLE -> RUN on i_start; RUN -> DRAIN on acceptance of beat NBEATS-1; DRAIN -> IDLE on the handshake of the o_last beat.
REQ-008 SHALL ignore i_start outside IDLE.
REQ-009 SHALL register i_mean[DATA_W-1:0], i_inv_sqrt and i_mode on i_start, hold them for the vector, and clear o_sat on the same edge.
REQ-010 SHALL use a 3-stage pipeline with valid bits v1..v3 and one global enable en = !v3 | i_ready; all stages SHALL hold when en=0.
REQ-011 SHALL drive o_ready = (state==RUN) & en.
REQ-012 SHALL keep a beat counter 0..NBEATS-1 that increments on each input handshake, resets on i_start, and carries a last tag down the pipe to o_last.
REQ-013 Stage 1 SHALL compute d = x - mean (or d = x in mode 1) at DATA_W+1 bits, then p = d * inv_sqrt at full width.
REQ-014 Stage 2 SHALL compute n = sat_DATA_W((p + 2^(FRAC-1)) >>> FRAC), then q = n * gamma at full width.
REQ-015 Stage 3 SHALL compute y = sat_DATA_W(((q + 2^(FRAC-1)) >>> FRAC) + beta).
REQ-016 Saturation SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clamp in stage 2 or 3 on a valid beat SHALL set o_sat.
REQ-017 Latency SHALL be 3 cycles from input handshake to o_valid when i_ready is held at 1; throughput SHALL be 1 beat/cycle.
REQ-018 o_data SHALL stay stable while o_valid & !i_ready.
REQ-019 Simultaneous input and output handshakes in one cycle SHALL both complete.
REQ-020 i_valid asserted in IDLE or DRAIN SHALL be ignored and no beat accepted.

Reset
REQ-021 On i_rst=1, synchronously: state=IDLE, v1..v3=0, counter=0, o_valid=0, o_last=0, o_busy=0, o_sat=0, o_ready=0, o_data=0, latched registers=0.
REQ-022 Reset mid-vector SHALL discard all in-flight beats, and no o_valid SHALL appear afterwards until a new i_start.

Structure
REQ-023 Package ln_pkg SHALL hold the state enum typedef (IDLE, RUN, DRAIN), default parameter constants and the saturate/round function.
REQ-024 The per-lane 3-stage datapath SHALL be sub-module ln_norm_lane, instantiated LANES times by generate; control and the FSM SHALL stay in the top level.

Verification (LANES=4, VEC_LEN=8, FRAC=10)
REQ-025 Basic: mode 0, mean=100, inv=1024, x=1124, gamma=1024, beta=5, i_ready=1 -> y=1029 in all lanes, 3 cycles after each handshake, o_last on beat 2 only.
REQ-026 RMS: same stimulus with mode 1 -> y=1129; mean has no effect.
REQ-027 Saturation: x=32767, mean=-32768, inv=1024, gamma=1024, beta=100 -> y=32767 and o_sat=1; o_sat clears on the next i_start.
REQ-028 Backpressure: i_ready toggles 1010... -> no beat lost or duplicated, o_data stable while stalled, o_ready low whenever v3 & !i_ready.
REQ-029 Reset mid-vector: i_rst asserted after 1 accepted beat -> next cycle o_valid=0, o_busy=0; a following vector completes normally.
REQ-030 Protocol: i_start during RUN and i_valid during IDLE -> both ignored; beat count and outputs unchanged.
